oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite-DMA controller for the CPU's write to $4014.
- Halts the CPU, reads 256 bytes from CPU page {page,00}..{page,FF} and writes each byte to PPU register $2004 (OAMDATA) through the PPU register port's req/ack handshake.
- Sits between the CPU core, the CPU memory bus arbiter and the PPU register interface.
- Sequences the PPU's sprite-RAM fill with NES-accurate CPU-cycle timing: 513 or 514 ticks.

Parameters:
- OAMREG, 3'd4, PPU register index driven on ppuaddr during writes.
- NBYTES, 256, bytes per transfer; must be a power of two ≤ 256.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tick  input  1  CPU-cycle enable; one clk-wide pulse per CPU cycle
- dmastart  input  1  one-clk pulse: CPU wrote $4014
- dmapage  input  8  data byte of that write; high address byte
- halt  output  1  stall request to CPU core
- busy  output  1  transfer in progress (state != IDLE)
- done  output  1  one-clk pulse at transfer completion
- rdaddr  output  16  CPU-bus read address
- rdreq  output  1  CPU-bus read request
- rdack  input  1  read complete; rddata valid this clk
- rddata  input  8  read data
- ppuaddr  output  3  PPU register select
- ppuwdata  output  8  PPU write data
- ppuwr  output  1  write strobe; equals ppureq
- ppureq  output  1  PPU register request
- ppuack  input  1  PPU write accepted

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, idx=0, page=0, buf=0, odd=0, ackd=0.
  - All outputs 0, except ppuaddr=OAMREG.
  - Outstanding requests drop immediately.
- odd flag: toggles on every tick in every state, including IDLE. It tracks CPU cycle parity.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - dmastart=1 → latch page=dmapage, idx=0, go to HALT on next clk.
  - dmastart in any other state is ignored; page is not relatched.
- HALT: on tick → ALIGN if odd=1, else READ. This is the dummy halt cycle.
- ALIGN: on tick → READ. This is the extra alignment cycle.
- READ:
  - rdreq=1 and rdaddr={page,idx}.
  - When rdack=1: buf<=rddata, ackd<=1, rdreq drops on the next clk.
  - On the first tick with ackd=1 (the ack clk itself counts): clear ackd, go to WRITE.
- WRITE:
  - ppureq=ppuwr=1, ppuaddr=OAMREG, ppuwdata=buf.
  - When ppuack=1: ackd<=1, ppureq drops on the next clk.
  - On the first tick with ackd=1: clear ackd, idx<=idx+1 (8-bit wrap).
  - If idx was NBYTES-1 → IDLE and pulse done for one clk; else → READ.
- Requests are held stable until their ack; exactly one ack is accepted per request. An ack while its req is low is ignored.
- rdack and tick in the same clk: both take effect, so the state advances that clk.
- Tick counts:
  - Zero-wait acks: 1 + (odd?1:0) + 2×NBYTES ticks from HALT entry to IDLE (513 or 514).
  - Slow acks stretch a phase by whole ticks only.
- halt: asserted combinationally whenever state != IDLE.
- busy: equals halt.
- Mid-transfer reset: abort, no done pulse; the partial OAM contents are left as written.

Test Plan:
- Even start: dmastart with dmapage=8'h02 while odd=0, zero-wait acks → rdaddr 16'h0200..16'h02FF in order; 256 PPU writes, each with ppuaddr=4; done after exactly 513 ticks; halt high for that whole span.
- Odd start: same as above with odd=1 at HALT → one ALIGN tick observed; done after 514 ticks.
- Data path: memory returns rddata=idx^8'hA5 → ppuwdata sequence equals 8'hA5, 8'hA4, …; no byte is duplicated or skipped; exactly 256 ppuack handshakes.
- Slow ack: rdack delayed 5 clks and ppuack delayed 3 clks on byte 7 → rdreq and ppureq hold steady until their acks; the state waits for the following tick; the next byte's address is 16'h0208.
- Retrigger: dmastart with dmapage=8'h07 issued mid-transfer → ignored; page stays 8'h02.
- Reset: reset low at byte 100 → rdreq, ppureq and halt drop asynchronously; no done pulse. A new dmastart after release restarts at idx 0.

Source files
------------

// File: rtl/oam_dma.sv
// oam_dma: $4014 sprite DMA; copies CPU page {page,00..FF} into PPU OAMDATA while halting the CPU.
// Latency 513/514 CPU ticks with zero-wait acks; each req is held until its ack, and slow acks stretch a phase by whole ticks.
module oam_dma #(
  parameter logic [2:0] OAMREG = 3'd4,
  parameter int         NBYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        dmastart,
  input  logic [7:0]  dmapage,
  output logic        halt,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdaddr,
  output logic        rdreq,
  input  logic        rdack,
  input  logic [7:0]  rddata,
  output logic [2:0]  ppuaddr,
  output logic [7:0]  ppuwdata,
  output logic        ppuwr,
  output logic        ppureq,
  input  logic        ppuack
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  localparam logic [7:0] LAST = 8'(NBYTES - 1);

  state_t     state;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] dbuf;
  logic       odd;
  logic       ackd;
  logic       rd_hs;
  logic       wr_hs;

  // An ack only counts while its own request is up.
  assign rd_hs    = rdreq & rdack;
  assign wr_hs    = ppureq & ppuack;
  assign halt     = (state != IDLE);
  assign busy     = halt;
  assign rdaddr   = {page, idx};
  assign ppuaddr  = OAMREG;
  assign ppuwdata = dbuf;
  assign ppuwr    = ppureq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= 8'd0;
      page   <= 8'd0;
      dbuf   <= 8'd0;
      odd    <= 1'b0;
      ackd   <= 1'b0;
      rdreq  <= 1'b0;
      ppureq <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (tick) odd <= ~odd;
      case (state)
        IDLE: begin
          if (dmastart) begin
            page  <= dmapage;
            idx   <= 8'd0;
            ackd  <= 1'b0;
            state <= HALT;
          end
        end
        HALT: begin
          // odd is the parity before this tick toggles it
          if (tick) begin
            if (odd) begin
              state <= ALIGN;
            end else begin
              state <= READ;
              rdreq <= 1'b1;
            end
          end
        end
        ALIGN: begin
          if (tick) begin
            state <= READ;
            rdreq <= 1'b1;
          end
        end
        READ: begin
          if (rd_hs) begin
            dbuf  <= rddata;
            rdreq <= 1'b0;
          end
          if (tick && (ackd || rd_hs)) begin
            ackd   <= 1'b0;
            state  <= WRITE;
            ppureq <= 1'b1;
          end else if (rd_hs) begin
            ackd <= 1'b1;
          end
        end
        WRITE: begin
          if (wr_hs) ppureq <= 1'b0;
          if (tick && (ackd || wr_hs)) begin
            ackd <= 1'b0;
            idx  <= idx + 8'd1;
            if (idx == LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              rdreq <= 1'b1;
            end
          end else if (wr_hs) begin
            ackd <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: random tick periods and ack delays, with a queue scoreboard fed at dmastart.
module tb_oam_dma;
  localparam int NB = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        dmastart = 1'b0;
  logic [7:0]  dmapage = 8'h00;
  logic        halt, busy, done, rdreq, ppuwr, ppureq;
  logic [15:0] rdaddr;
  logic [2:0]  ppuaddr;
  logic [7:0]  ppuwdata;
  logic        rdack = 1'b0;
  logic        ppuack = 1'b0;
  logic [7:0]  rddata = 8'h00;

  oam_dma dut (
    .clk(clk), .reset(reset), .tick(tick), .dmastart(dmastart), .dmapage(dmapage),
    .halt(halt), .busy(busy), .done(done), .rdaddr(rdaddr), .rdreq(rdreq),
    .rdack(rdack), .rddata(rddata), .ppuaddr(ppuaddr), .ppuwdata(ppuwdata),
    .ppuwr(ppuwr), .ppureq(ppureq), .ppuack(ppuack)
  );

  always #5 clk = ~clk;

  // environment knobs, set by the stimulus while idle
  int         per = 1;
  logic [7:0] key = 8'h00;
  bit         spur = 1'b0;
  int         rd_dly [NB];
  int         wr_dly [NB];
  int         tcount = 0;

  // scoreboard
  logic [15:0] exp_rd [$];
  logic [7:0]  exp_wr [$];
  int          exp_sum [$];
  int          checks = 0;
  int          errors = 0;

  int          rd_cnt = 0, wr_cnt = 0, bt = 0, par = 0, done_cnt = 0;
  bit          rd_open = 1'b0, wr_open = 1'b0, halt_prev = 1'b0;
  logic [15:0] rd_held = 16'h0;
  logic [7:0]  wr_held = 8'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // tick generator and memory / PPU responders, driven just after each rising edge
  initial begin
    int tcnt, rcnt, wcnt;
    logic [7:0] rbyte, wbyte;
    bit rd_real, wr_real;
    tcnt = 0; rcnt = 0; wcnt = 0; rbyte = 8'd0; wbyte = 8'd0; rd_real = 0; wr_real = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        tick = 1'b0; tcount = 0; tcnt = 0; rdack = 1'b0; ppuack = 1'b0;
        rcnt = 0; wcnt = 0; rbyte = 8'd0; wbyte = 8'd0; rd_real = 0; wr_real = 0;
      end else begin
        tick = (tcnt == 0);
        if (tick) tcount++;
        tcnt = (tcnt + 1 >= per) ? 0 : tcnt + 1;
        if (rd_real) begin rd_real = 0; rbyte = rbyte + 8'd1; end
        if (wr_real) begin wr_real = 0; wbyte = wbyte + 8'd1; end
        if (!halt) begin rbyte = 8'd0; wbyte = 8'd0; end
        rdack = 1'b0;
        if (rdreq) begin
          if (rcnt >= rd_dly[rbyte]) begin
            rdack = 1'b1; rd_real = 1; rcnt = 0; rddata = rdaddr[7:0] ^ key;
          end else rcnt++;
        end else if (spur && $urandom_range(0, 3) == 0) begin
          rdack = 1'b1; rddata = 8'hEE;
        end
        ppuack = 1'b0;
        if (ppureq) begin
          if (wcnt >= wr_dly[wbyte]) begin
            ppuack = 1'b1; wr_real = 1; wcnt = 0;
          end else wcnt++;
        end else if (spur && $urandom_range(0, 3) == 0) begin
          ppuack = 1'b1;
        end
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents a request or done
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      exp_rd.delete(); exp_wr.delete(); exp_sum.delete();
      rd_open = 0; wr_open = 0; rd_cnt = 0; wr_cnt = 0; bt = 0; halt_prev = 0;
    end else begin
      if (tick && halt) begin
        if (bt == 0) par = (tcount - 1) & 1;
        bt++;
      end
      if (rdreq) begin
        if (!rd_open) begin
          rd_open = 1; rd_held = rdaddr;
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_extra: read %h issued, none expected", rdaddr);
          end else chk("rd_addr", 32'(rdaddr), 32'(exp_rd.pop_front()));
          chk("busy_in_read", 32'(busy), 32'd1);
        end else chk("rdaddr_stable", 32'(rdaddr), 32'(rd_held));
        if (rdack) begin rd_open = 0; rd_cnt++; end
      end else if (rd_open) begin
        chk("rdreq_hold", 32'(rdreq), 32'd1);
        rd_open = 0;
      end
      if (ppureq) begin
        if (!wr_open) begin
          wr_open = 1; wr_held = ppuwdata;
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_extra: write %h issued, none expected", ppuwdata);
          end else chk("ppuwdata", 32'(ppuwdata), 32'(exp_wr.pop_front()));
          chk("ppuaddr", 32'(ppuaddr), 32'd4);
          chk("ppuwr", 32'(ppuwr), 32'd1);
        end else chk("ppuwdata_stable", 32'(ppuwdata), 32'(wr_held));
        if (ppuack) begin wr_open = 0; wr_cnt++; end
      end else if (wr_open) begin
        chk("ppureq_hold", 32'(ppureq), 32'd1);
        wr_open = 0;
      end
      if (done) begin
        if (exp_sum.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_extra: done pulse with no transfer expected");
        end else begin
          chk("done_ticks", 32'(bt), 32'(1 + par + exp_sum.pop_front()));
          chk("wr_count", 32'(wr_cnt), 32'(NB));
          chk("rd_count", 32'(rd_cnt), 32'(NB));
          chk("halt_after_done", 32'(halt), 32'd0);
          chk("busy_after_done", 32'(busy), 32'd0);
          chk("ppuwr_idle", 32'(ppuwr), 32'd0);
        end
        bt = 0; rd_cnt = 0; wr_cnt = 0; done_cnt++;
      end else if (halt_prev && !halt) begin
        chk("halt_span", 32'(halt), 32'd1);
      end
      halt_prev = halt;
    end
  end

  // mode: 0 zero-wait, 1 slow byte 7, 2 random delays, 3 constant delay 2
  task automatic xfer(input logic [7:0] pg, input logic [7:0] k, input int p, input int want_par,
                      input bit sp, input int mode, input bit retrig, input int abort_at);
    int sum, to, d0;
    bit fired;
    to = 0;
    while (halt && to < 50) begin @(negedge clk); to++; end
    per = p; key = k; spur = sp;
    for (int i = 0; i < NB; i++) begin
      rd_dly[i] = 0; wr_dly[i] = 0;
      if (mode == 2 && $urandom_range(0, 7) == 0) rd_dly[i] = int'($urandom_range(1, 4));
      if (mode == 2 && $urandom_range(0, 7) == 0) wr_dly[i] = int'($urandom_range(1, 4));
      if (mode == 3) begin rd_dly[i] = 2; wr_dly[i] = 2; end
    end
    if (mode == 1) begin rd_dly[7] = 5; wr_dly[7] = 3; end
    // each phase lasts until the first tick at or after its ack: ceil((delay+1)/period)
    sum = 0;
    for (int i = 0; i < NB; i++) sum += (rd_dly[i] + p) / p + (wr_dly[i] + p) / p;
    @(negedge clk);
    if (want_par >= 0) begin
      to = 0;
      while ((tcount % 2) != want_par && to < 20) begin @(negedge clk); to++; end
      chk("start_parity", 32'(tcount % 2), 32'(want_par));
    end
    for (int i = 0; i < NB; i++) begin
      exp_rd.push_back({pg, 8'(i)});
      exp_wr.push_back(8'(i) ^ k);
    end
    exp_sum.push_back(sum);
    d0 = done_cnt;
    dmapage = pg; dmastart = 1'b1;
    @(negedge clk);
    dmastart = 1'b0; dmapage = 8'($urandom);
    to = 0; fired = 0;
    while (done_cnt == d0 && to < 20000) begin
      @(negedge clk); to++;
      dmastart = 1'b0;
      if (retrig && !fired && wr_cnt == 50) begin dmastart = 1'b1; dmapage = 8'h07; fired = 1; end
      if (abort_at >= 0 && wr_cnt >= abort_at) break;
    end
    dmastart = 1'b0;
    if (abort_at >= 0) begin
      to = 0;
      while (!((rdreq && !rdack) || (ppureq && !ppuack)) && to < 50) begin @(negedge clk); to++; end
      @(posedge clk); #2;
      reset = 1'b0; #1;
      chk("abort_halt", 32'(halt), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rdreq", 32'(rdreq), 32'd0);
      chk("abort_ppureq", 32'(ppureq), 32'd0);
      chk("abort_ppuwr", 32'(ppuwr), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
    end else if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles for page %h", to, pg);
    end
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin rd_dly[i] = 0; wr_dly[i] = 0; end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdreq", 32'(rdreq), 32'd0);
    chk("rst_ppureq", 32'(ppureq), 32'd0);
    chk("rst_ppuwr", 32'(ppuwr), 32'd0);
    chk("rst_ppuaddr", 32'(ppuaddr), 32'd4);
    chk("rst_rdaddr", 32'(rdaddr), 32'd0);
    chk("rst_ppuwdata", 32'(ppuwdata), 32'd0);
    reset = 1'b1;
    xfer(8'h02, 8'hA5, 1, 0, 1'b0, 0, 1'b0, -1);
    xfer(8'h02, 8'hA5, 2, 1, 1'b0, 0, 1'b0, -1);
    xfer(8'h02, 8'hA5, 3, -1, 1'b0, 1, 1'b1, -1);
    xfer(8'h02, 8'hA5, 1, -1, 1'b0, 3, 1'b0, 100);
    xfer(8'h3C, 8'h5A, 1, -1, 1'b0, 0, 1'b0, -1);
    for (int n = 0; n < 4; n++)
      xfer(8'($urandom), 8'($urandom), int'($urandom_range(1, 3)), -1, 1'b1, 2, 1'b0, -1);
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
